// File: rtl/rv_pkg.sv
// Shared definitions for the fetch stage: jump encodings, instruction field positions, fetch states.
package rv_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned INS_W_DEF  = 16;

  // Controller jump select encodings; 2'b11 is reserved and behaves as JUMP_NONE.
  localparam logic [1:0] JUMP_NONE = 2'b00;
  localparam logic [1:0] JUMP_REL  = 2'b01;
  localparam logic [1:0] JUMP_REG  = 2'b10;

  // Instruction field positions.
  localparam int unsigned OPC_HI   = 15;
  localparam int unsigned OPC_LO   = 11;
  localparam int unsigned RD_HI    = 10;
  localparam int unsigned RD_LO    = 8;
  localparam int unsigned IMM8_HI  = 7;
  localparam int unsigned IMM8_LO  = 0;
  localparam int unsigned IMM11_HI = 10;
  localparam int unsigned IMM11_LO = 0;
  localparam int unsigned INSM_HI  = 15;
  localparam int unsigned INSM_LO  = 8;
  localparam int unsigned INSL_HI  = 1;
  localparam int unsigned INSL_LO  = 0;
  localparam int unsigned IMM11_W  = IMM11_HI - IMM11_LO + 1;

  typedef enum logic [1:0] {
    ST_START = 2'b00,
    ST_REQ   = 2'b01,
    ST_HOLD  = 2'b10,
    ST_HALT  = 2'b11
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port: fetch unit is the master, memory is the slave.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned INS_W  = 16
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [INS_W-1:0]  imem_rdata;
  logic              imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ack
  );
endinterface

// File: rtl/fetch_unit_next_pc_calc.sv
// Next-PC selection: Jump over Branch over sequential, all modulo ADDR_W.
module next_pc_calc
  import rv_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic [ADDR_W-1:0]  pc,
  input  logic [IMM11_W-1:0] imm11,
  input  logic               branch,
  input  logic [1:0]         jump,
  input  logic [ADDR_W-1:0]  reg_target,
  output logic [ADDR_W-1:0]  next_pc_c
);

  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] off11;
  logic [ADDR_W-1:0] off8;

  assign pc_plus1 = pc + ADDR_W'(1);
  // Signed size casts sign-extend the immediates to the address width.
  assign off11 = ADDR_W'($signed(imm11));
  assign off8  = ADDR_W'($signed(imm11[IMM8_HI:IMM8_LO]));

  // Priority mux; reserved jump code falls through to the branch/sequential path.
  always_comb begin
    next_pc_c = pc_plus1;
    if (jump == JUMP_REL) begin
      next_pc_c = pc_plus1 + off11;
    end else if (jump == JUMP_REG) begin
      next_pc_c = reg_target;
    end else if (branch) begin
      next_pc_c = pc_plus1 + off8;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns PC and IR, fetches over a req/ack port, halts on Done.
module fetch_unit
  import rv_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter int unsigned       INS_W    = INS_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              Buff_PC,
  input  logic              Branch,
  input  logic [1:0]        Jump,
  input  logic              Done,
  input  logic [ADDR_W-1:0] RegTarget,
  fetch_unit_if.master      imem,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] PCplus1,
  output logic [INS_W-1:0]  Ins,
  output logic [7:0]        InsM,
  output logic [1:0]        InsL,
  output logic              Ins_valid,
  output logic              seq_err
);

  fetch_state_e      state;
  logic [ADDR_W-1:0] pc_q;
  logic [INS_W-1:0]  ins_q;
  logic              req_q;
  logic              valid_q;
  logic              err_q;
  logic [ADDR_W-1:0] next_pc;
  logic              bad_buff;
  logic              bad_ack;

  next_pc_calc #(
    .ADDR_W (ADDR_W)
  ) u_next_pc (
    .pc         (pc_q),
    .imm11      (ins_q[IMM11_HI:IMM11_LO]),
    .branch     (Branch),
    .jump       (Jump),
    .reg_target (RegTarget),
    .next_pc_c  (next_pc)
  );

  // Protocol violations: commit strobe before an instruction is held, or a stray ack.
  assign bad_buff = Buff_PC && ((state == ST_START) || (state == ST_REQ));
  assign bad_ack  = imem.imem_ack && (state != ST_REQ);

  // Fetch FSM with registered request, valid and error flags.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state   <= ST_START;
      pc_q    <= RESET_PC;
      ins_q   <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (bad_buff || bad_ack) begin
        err_q <= 1'b1;
      end
      case (state)
        ST_START: begin
          state <= ST_REQ;
          req_q <= 1'b1;
        end
        ST_REQ: begin
          if (imem.imem_ack) begin
            ins_q   <= imem.imem_rdata;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            state   <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (Done) begin
            valid_q <= 1'b0;
            state   <= ST_HALT;
          end else if (Buff_PC) begin
            pc_q    <= next_pc;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            state   <= ST_REQ;
          end
        end
        ST_HALT: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
        default: begin
          state <= ST_START;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign PC             = pc_q;
  assign PCplus1        = pc_q + ADDR_W'(1);
  assign Ins            = ins_q;
  assign InsM           = ins_q[INSM_HI:INSM_LO];
  assign InsL           = ins_q[INSL_HI:INSL_LO];
  assign Ins_valid      = valid_q;
  assign seq_err        = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with a behavioural req/ack instruction memory.
module tb_fetch_unit;

  logic        clk;
  logic        Rst;
  logic        Buff_PC;
  logic        Branch;
  logic [1:0]  Jump;
  logic        Done;
  logic [15:0] RegTarget;
  logic [15:0] PC;
  logic [15:0] PCplus1;
  logic [15:0] Ins;
  logic [7:0]  InsM;
  logic [1:0]  InsL;
  logic        Ins_valid;
  logic        seq_err;

  fetch_unit_if imem_bus ();

  fetch_unit dut (
    .clk       (clk),
    .Rst       (Rst),
    .Buff_PC   (Buff_PC),
    .Branch    (Branch),
    .Jump      (Jump),
    .Done      (Done),
    .RegTarget (RegTarget),
    .imem      (imem_bus),
    .PC        (PC),
    .PCplus1   (PCplus1),
    .Ins       (Ins),
    .InsM      (InsM),
    .InsL      (InsL),
    .Ins_valid (Ins_valid),
    .seq_err   (seq_err)
  );

  typedef struct {
    logic [15:0] pc;
    logic [15:0] ins;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mem [logic [15:0]];
  int          mem_delay;
  logic        stray_ack;
  int          n_cmp;
  int          n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory model: acks after mem_delay waiting cycles of a held request, or on demand for a stray ack.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (stray_ack) begin
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 16'hDEAD;
        stray_ack           = 1'b0;
        wait_cnt            = 0;
      end else if (imem_bus.imem_req) begin
        if (wait_cnt >= mem_delay) begin
          imem_bus.imem_ack   = 1'b1;
          imem_bus.imem_rdata = mem.exists(imem_bus.imem_addr) ? mem[imem_bus.imem_addr] : 16'h0000;
          wait_cnt            = 0;
        end else begin
          imem_bus.imem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        imem_bus.imem_ack = 1'b0;
        wait_cnt          = 0;
      end
    end
  end

  // Monitor: each new valid instruction is compared against the oldest expectation.
  initial begin
    logic prev_valid;
    exp_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (Ins_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_fetch: got pc %h ins %h expected no fetch", PC, Ins);
        end else begin
          e = exp_q.pop_front();
          check("fetch_pc", PC, e.pc);
          check("fetch_ins", Ins, e.ins);
          check("fetch_insm", 16'(InsM), 16'(e.ins[15:8]));
          check("fetch_insl", 16'(InsL), 16'(e.ins[1:0]));
        end
      end
      prev_valid = Ins_valid;
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // Commit a new PC from HOLD at a negedge; returns at the first REQ cycle.
  task automatic issue(input logic br, input logic [1:0] jp, input logic [15:0] rt,
                       input logic [15:0] exp_pc, input logic [15:0] exp_ins);
    exp_q.push_back('{pc: exp_pc, ins: exp_ins});
    Branch    = br;
    Jump      = jp;
    RegTarget = rt;
    Buff_PC   = 1'b1;
    @(negedge clk);
    Buff_PC = 1'b0;
    Branch  = 1'b0;
    Jump    = 2'b00;
    check("req_after_buff", 16'(imem_bus.imem_req), 16'h1);
    check("addr_after_buff", imem_bus.imem_addr, exp_pc);
    check("valid_drop", 16'(Ins_valid), 16'h0);
  endtask

  task automatic wait_valid(input int budget);
    int i;
    i = 0;
    while (!Ins_valid && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("valid_timeout", 16'(Ins_valid), 16'h1);
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    Rst = 1'b1;
    Buff_PC = 1'b0;
    Branch = 1'b0;
    Jump = 2'b00;
    Done = 1'b0;
    RegTarget = 16'h0000;
    mem_delay = 0;
    stray_ack = 1'b0;
    mem[16'h0000] = 16'h0800;
    mem[16'h0001] = 16'h9999;
    mem[16'h0002] = 16'hAAAA;
    mem[16'h0010] = 16'h1111;
    mem[16'h0011] = 16'h2222;
    mem[16'h0020] = 16'hC0FE;
    mem[16'h001F] = 16'h4444;
    mem[16'h0026] = 16'h3333;
    mem[16'h1234] = 16'h00FF;
    mem[16'h0040] = 16'h5555;
    mem[16'h0041] = 16'h6666;
    mem[16'h00A8] = 16'h7777;
    mem[16'hFFFF] = 16'h8888;

    // Reset state, then first fetch two edges after release.
    repeat (2) @(negedge clk);
    check("rst_req", 16'(imem_bus.imem_req), 16'h0);
    check("rst_valid", 16'(Ins_valid), 16'h0);
    check("rst_pc", PC, 16'h0000);
    check("rst_pcplus1", PCplus1, 16'h0001);
    check("rst_ins", Ins, 16'h0000);
    check("rst_err", 16'(seq_err), 16'h0);
    exp_q.push_back('{pc: 16'h0000, ins: 16'h0800});
    Rst = 1'b0;
    @(negedge clk);
    check("first_req", 16'(imem_bus.imem_req), 16'h1);
    check("first_addr", imem_bus.imem_addr, 16'h0000);
    check("first_valid_early", 16'(Ins_valid), 16'h0);
    @(negedge clk);
    check("first_valid", 16'(Ins_valid), 16'h1);
    check("first_insm", 16'(InsM), 16'h0008);

    // Sequential step from 0x0010.
    issue(1'b0, 2'b10, 16'h0010, 16'h0010, 16'h1111);
    wait_valid(20);
    issue(1'b0, 2'b00, 16'h0000, 16'h0011, 16'h2222);
    wait_valid(20);
    check("seq_pc", PC, 16'h0011);
    check("seq_pcplus1", PCplus1, 16'h0012);

    // Branch -2 from 0x0020, relative jump +5, register jump, Jump over Branch.
    issue(1'b0, 2'b10, 16'h0020, 16'h0020, 16'hC0FE);
    wait_valid(20);
    issue(1'b1, 2'b00, 16'h0000, 16'h001F, 16'h4444);
    wait_valid(20);
    mem[16'h0020] = 16'h8005;
    issue(1'b0, 2'b10, 16'h0020, 16'h0020, 16'h8005);
    wait_valid(20);
    issue(1'b0, 2'b01, 16'h0000, 16'h0026, 16'h3333);
    wait_valid(20);
    issue(1'b0, 2'b10, 16'h1234, 16'h1234, 16'h00FF);
    wait_valid(20);
    issue(1'b1, 2'b10, 16'h0040, 16'h0040, 16'h5555);
    wait_valid(20);
    // Reserved jump code: sequential, then branch +0x66 from 0x0041.
    issue(1'b0, 2'b11, 16'h0000, 16'h0041, 16'h6666);
    wait_valid(20);
    issue(1'b1, 2'b11, 16'h0000, 16'h00A8, 16'h7777);
    wait_valid(20);

    // Wrap at the top of the address space.
    issue(1'b0, 2'b10, 16'hFFFF, 16'hFFFF, 16'h8888);
    wait_valid(20);
    check("wrap_pcplus1", PCplus1, 16'h0000);
    issue(1'b0, 2'b00, 16'h0000, 16'h0000, 16'h0800);
    wait_valid(20);

    // Delayed ack: request and address held, no valid until ack.
    mem_delay = 5;
    issue(1'b0, 2'b00, 16'h0000, 16'h0001, 16'h9999);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("delay_req", 16'(imem_bus.imem_req), 16'h1);
      check("delay_addr", imem_bus.imem_addr, 16'h0001);
      check("delay_valid", 16'(Ins_valid), 16'h0);
    end
    wait_valid(20);

    // Buff_PC while a request is outstanding is ignored and flagged.
    mem_delay = 3;
    issue(1'b0, 2'b00, 16'h0000, 16'h0002, 16'hAAAA);
    check("err_before", 16'(seq_err), 16'h0);
    Buff_PC = 1'b1;
    @(negedge clk);
    Buff_PC = 1'b0;
    check("err_set", 16'(seq_err), 16'h1);
    check("err_pc_kept", PC, 16'h0002);
    wait_valid(20);
    mem_delay = 0;

    // Done halts; later Buff_PC pulses never produce a request.
    Done = 1'b1;
    Buff_PC = 1'b1;
    @(negedge clk);
    Done = 1'b0;
    Buff_PC = 1'b0;
    check("halt_req", 16'(imem_bus.imem_req), 16'h0);
    check("halt_valid", 16'(Ins_valid), 16'h0);
    check("halt_pc", PC, 16'h0002);
    for (int k = 0; k < 3; k++) begin
      Buff_PC = 1'b1;
      @(negedge clk);
      Buff_PC = 1'b0;
      check("halt_req_pulse", 16'(imem_bus.imem_req), 16'h0);
      @(negedge clk);
      check("halt_req_idle", 16'(imem_bus.imem_req), 16'h0);
    end
    check("err_sticky", 16'(seq_err), 16'h1);

    // Reset mid-request, then a stray ack right after release.
    mem_delay = 10;
    Rst = 1'b1;
    @(negedge clk);
    check("rst2_err", 16'(seq_err), 16'h0);
    Rst = 1'b0;
    @(negedge clk);
    check("rst2_req", 16'(imem_bus.imem_req), 16'h1);
    Rst = 1'b1;
    #1;
    check("midreq_req_drop", 16'(imem_bus.imem_req), 16'h0);
    check("midreq_pc", PC, 16'h0000);
    check("midreq_ins", Ins, 16'h0000);
    check("midreq_valid", 16'(Ins_valid), 16'h0);
    @(posedge clk);
    #1;
    Rst = 1'b0;
    stray_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("stray_ins", Ins, 16'h0000);
    check("stray_valid", 16'(Ins_valid), 16'h0);
    check("stray_req", 16'(imem_bus.imem_req), 16'h1);
    check("stray_err", 16'(seq_err), 16'h1);
    exp_q.push_back('{pc: 16'h0000, ins: 16'h0800});
    wait_valid(30);
    @(negedge clk);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_fetches: got %0d outstanding expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Upstream stage of the multicycle RISC Controller: owns the PC and the instruction register (IR).
- Fetches 16-bit instructions over a req/ack instruction-memory port and presents them to the Controller as InsM = Ins[15:8] and InsL = Ins[1:0].
- Computes the next PC from the Controller's Buff_PC, Branch and Jump outputs, and stops fetching when Done is asserted.

Parameters:
- ADDR_W, 16, PC and instruction-memory address width.
- INS_W, 16, instruction width; fixed at 16 by the ISA.
- RESET_PC, 16'h0000, PC value after reset.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- Rst  in  1  reset, asynchronous, active-high.
- Buff_PC  in  1  Controller strobe: commit next PC and start the next fetch.
- Branch  in  1  Controller: conditional branch taken (condition already resolved from PSW_NZC).
- Jump  in  2  Controller jump select: 00 none, 01 PC-relative imm11, 10 register target, 11 reserved (treated as 00).
- Done  in  1  Controller halt indication (HLT).
- RegTarget  in  ADDR_W  register-file read value used as the jump target when Jump=10.
- imem_req  out  1  instruction-memory read request.
- imem_addr  out  ADDR_W  read address; always equals PC.
- imem_rdata  in  INS_W  read data; valid in the cycle imem_ack=1.
- imem_ack  in  1  read completion, one-cycle pulse.
- PC  out  ADDR_W  address of the instruction currently in IR.
- PCplus1  out  ADDR_W  PC+1, feeding the JAL link-value path (PCplus1orWB).
- Ins  out  INS_W  IR contents.
- InsM  out  8  Ins[15:8].
- InsL  out  2  Ins[1:0].
- Ins_valid  out  1  IR holds a valid instruction.
- seq_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (asynchronous, any state): state=START; PC=RESET_PC; Ins=16'h0000; imem_req=0; Ins_valid=0; seq_err=0.
  - Reset mid-fetch abandons the request; imem_req drops immediately.
  - An imem_ack arriving after reset release for an abandoned request is ignored, because the FSM is still in START.
- FSM states: START, REQ, HOLD, HALT.
  - START: imem_req=0. Always moves to REQ on the next edge.
  - REQ: imem_req=1 and imem_addr=PC, both held until ack. On imem_ack: Ins<=imem_rdata, move to HOLD. imem_req is low in the cycle after the ack.
  - HOLD: Ins_valid=1; IR and PC are stable.
    - Buff_PC=1 and Done=0: PC<=next_pc, Ins_valid drops, move to REQ.
    - Done=1 (with or without Buff_PC): move to HALT, PC unchanged.
  - HALT: Ins_valid=0, imem_req=0. Leaves only via Rst.
- next_pc priority: Jump over Branch over sequential.
  - Jump=01: PC+1+sext(Ins[10:0]).
  - Jump=10: RegTarget.
  - Branch=1 (Jump=00 or 11): PC+1+sext(Ins[7:0]).
  - Otherwise: PC+1.
- Arithmetic: all ADDR_W-bit modulo, so 16'hFFFF+1 wraps to 16'h0000 and negative offsets wrap below 0.
- PCplus1 is combinational from PC.
- Timing:
  - Minimum Buff_PC-to-Ins_valid latency with zero-wait memory (ack in the first REQ cycle) is 2 cycles.
  - First Ins_valid after reset release is at the earliest 2 edges after leaving reset.
- Boundary rules:
  - Buff_PC in START or REQ: ignored, and seq_err<=1.
  - imem_ack outside REQ: ignored, and seq_err<=1.
  - imem_rdata is sampled only on an ack cycle.

Decomposition:
- Shared package rv_pkg holds:
  - JUMP_NONE/JUMP_REL/JUMP_REG localparams;
  - opcode field positions [15:11], [10:8], [7:0], [10:0];
  - fetch state encodings.
- One natural sub-module: next_pc_calc, the combinational next-PC mux and adder; the FSM and registers stay in fetch_unit.

Test Plan:
- Reset then zero-wait memory returning 16'h0800 at address 0 -> imem_addr=0; Ins_valid=1 two edges after reset release; InsM=8'h08; InsL=2'b00.
- HOLD at PC=16'h0010, pulse Buff_PC with Branch=0, Jump=00 -> PC=16'h0011 and PCplus1=16'h0012; next fetch at 16'h0011.
- PC=16'h0020 with Ins=16'hC0FE and Branch=1 -> PC=16'h001F (offset -2). With Ins=16'h8005 and Jump=01 -> PC=16'h0026. With Jump=10 and RegTarget=16'h1234 -> PC=16'h1234. With Branch=1 and Jump=10 together -> Jump wins, PC=RegTarget.
- PC=16'hFFFF, sequential Buff_PC -> PC=16'h0000. Memory ack delayed 5 cycles -> imem_req held high 5 cycles with a stable address, and Ins_valid stays 0 until after the ack.
- Done=1 in HOLD -> HALT; no further imem_req while Buff_PC pulses continue. Buff_PC during REQ -> seq_err=1, held until Rst.
- Rst asserted mid-REQ, then a stray ack just after release -> imem_req=0 immediately; PC=RESET_PC; the stray ack is not latched into Ins.
